reg_read_stage: RTL and testbench

- Register-read pipeline stage for one execute pipe; one instance per pipe, NUM_EX_PIPES instances total.
- Accepts issued uops, drives the physical register file read port, and merges same-cycle writebacks from every execute pipe through a bypass network.
- Delivers a registered uop with operand values to its execute pipe under a valid/ready handshake.
- Two internal registers: slot A (address phase) and slot B (operand/output phase).

---
 rtl/reg_read_stage.sv | 144 ++++++++++++++
 tb/tb_reg_read_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_read_stage.sv
`timescale 1ns/1ps
`default_nettype none
// =====================================================================
// reg_read_stage : register-read stage, PRF read port plus WB bypass
// Rev 1.0
// =====================================================================
module reg_read_stage #(
  parameter int NUM_PREGS    = 64,
  parameter int NUM_EX_PIPES = 8,
  parameter int PAYLOAD_W    = 48,
  localparam int PW          = $clog2(NUM_PREGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       is_valid,
  output logic                       is_ready,
  input  logic [PW-1:0]              is_src1_reg,
  input  logic [PW-1:0]              is_src2_reg,
  input  logic                       is_src1_used,
  input  logic                       is_src2_used,
  input  logic [PW-1:0]              is_dst_reg,
  input  logic [PAYLOAD_W-1:0]       is_payload,
  output logic [PW-1:0]              prf_src1_reg,
  output logic [PW-1:0]              prf_src2_reg,
  input  logic [31:0]                prf_src1_val,
  input  logic [31:0]                prf_src2_val,
  input  logic [NUM_EX_PIPES-1:0]    wb_valid,
  input  logic [NUM_EX_PIPES*PW-1:0] wb_dst_index,
  input  logic [NUM_EX_PIPES*32-1:0] wb_dst_val,
  output logic                       ex_valid,
  input  logic                       ex_ready,
  output logic [31:0]                ex_src1_val,
  output logic [31:0]                ex_src2_val,
  output logic [PW-1:0]              ex_dst_reg,
  output logic [PAYLOAD_W-1:0]       ex_payload
);

  typedef struct packed {
    logic [PW-1:0]        src1;
    logic [PW-1:0]        src2;
    logic                 used1;
    logic                 used2;
    logic [PW-1:0]        dst;
    logic [PAYLOAD_W-1:0] payload;
  } slot_a_t;

  typedef struct packed {
    slot_a_t     uop;
    logic [31:0] val1;
    logic [31:0] val2;
  } slot_b_t;

  slot_a_t     a_q, a_d;
  slot_b_t     b_q, b_d;
  logic        a_valid_q, a_valid_d;
  logic        b_valid_q, b_valid_d;
  logic        adv_a, adv_b;
  logic [32:0] byp1_a, byp2_a, byp1_b, byp2_b;

  // Returns {hit, value}; later (higher) pipes overwrite earlier hits.
  function automatic logic [32:0] bypass(
    input logic [PW-1:0]              src,
    input logic [NUM_EX_PIPES-1:0]    vld,
    input logic [NUM_EX_PIPES*PW-1:0] idx,
    input logic [NUM_EX_PIPES*32-1:0] val
  );
    logic [32:0] r;
    r = '0;
    for (int i = 0; i < NUM_EX_PIPES; i++) begin
      if (vld[i] && (idx[i*PW +: PW] == src)) r = {1'b1, val[i*32 +: 32]};
    end
    return r;
  endfunction

  assign adv_b    = b_valid_q & ex_ready;
  assign adv_a    = a_valid_q & (~b_valid_q | adv_b);
  assign is_ready = ~a_valid_q | adv_a;

  always_comb begin
    byp1_a    = bypass(a_q.src1, wb_valid, wb_dst_index, wb_dst_val);
    byp2_a    = bypass(a_q.src2, wb_valid, wb_dst_index, wb_dst_val);
    byp1_b    = bypass(b_q.uop.src1, wb_valid, wb_dst_index, wb_dst_val);
    byp2_b    = bypass(b_q.uop.src2, wb_valid, wb_dst_index, wb_dst_val);
    a_d       = a_q;
    b_d       = b_q;
    a_valid_d = a_valid_q;
    b_valid_d = b_valid_q;

    if (is_valid && is_ready) begin
      a_valid_d  = 1'b1;
      a_d.src1    = is_src1_reg;
      a_d.src2    = is_src2_reg;
      a_d.used1   = is_src1_used;
      a_d.used2   = is_src2_used;
      a_d.dst     = is_dst_reg;
      a_d.payload = is_payload;
    end else if (adv_a) begin
      a_valid_d = 1'b0;
    end

    if (adv_a) begin
      b_valid_d = 1'b1;
      b_d.uop   = a_q;
      b_d.val1  = !a_q.used1 ? 32'd0 : (byp1_a[32] ? byp1_a[31:0] : prf_src1_val);
      b_d.val2  = !a_q.used2 ? 32'd0 : (byp2_a[32] ? byp2_a[31:0] : prf_src2_val);
    end else if (b_valid_q && !adv_b) begin
      // Stalled in B: keep catching producers that finish during backpressure.
      if (b_q.uop.used1 && byp1_b[32]) b_d.val1 = byp1_b[31:0];
      if (b_q.uop.used2 && byp2_b[32]) b_d.val2 = byp2_b[31:0];
    end else if (adv_b) begin
      b_valid_d = 1'b0;
    end

    if (flush) begin
      a_valid_d = 1'b0;
      b_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
    end
  end

  assign prf_src1_reg = a_q.src1;
  assign prf_src2_reg = a_q.src2;
  assign ex_valid     = b_valid_q;
  assign ex_src1_val  = b_q.val1;
  assign ex_src2_val  = b_q.val2;
  assign ex_dst_reg   = b_q.uop.dst;
  assign ex_payload   = b_q.uop.payload;

endmodule
`default_nettype wire

// File: tb/tb_reg_read_stage.sv
`timescale 1ns/1ps
`default_nettype none
// =====================================================================
// tb_reg_read_stage : directed scoreboard bench for reg_read_stage
// Rev 1.0
// =====================================================================
module tb_reg_read_stage;

  localparam int PW = 6;

  typedef struct packed {
    logic [31:0] v1;
    logic [31:0] v2;
    logic [5:0]  dst;
    logic [47:0] pl;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, flush, is_valid, is_ready;
  logic [5:0]   is_src1_reg, is_src2_reg, is_dst_reg;
  logic         is_src1_used, is_src2_used;
  logic [47:0]  is_payload;
  logic [5:0]   prf_src1_reg, prf_src2_reg;
  logic [31:0]  prf_src1_val, prf_src2_val;
  logic [7:0]   wb_valid;
  logic [47:0]  wb_dst_index;
  logic [255:0] wb_dst_val;
  logic         ex_valid, ex_ready;
  logic [31:0]  ex_src1_val, ex_src2_val;
  logic [5:0]   ex_dst_reg;
  logic [47:0]  ex_payload;

  logic [31:0] prf [64];
  exp_t        sb [$];
  int          total = 0;
  int          bad   = 0;
  int          n_out = 0;

  assign prf_src1_val = prf[prf_src1_reg];
  assign prf_src2_val = prf[prf_src2_reg];

  reg_read_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .is_valid(is_valid), .is_ready(is_ready),
    .is_src1_reg(is_src1_reg), .is_src2_reg(is_src2_reg),
    .is_src1_used(is_src1_used), .is_src2_used(is_src2_used),
    .is_dst_reg(is_dst_reg), .is_payload(is_payload),
    .prf_src1_reg(prf_src1_reg), .prf_src2_reg(prf_src2_reg),
    .prf_src1_val(prf_src1_val), .prf_src2_val(prf_src2_val),
    .wb_valid(wb_valid), .wb_dst_index(wb_dst_index), .wb_dst_val(wb_dst_val),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_src1_val(ex_src1_val), .ex_src2_val(ex_src2_val),
    .ex_dst_reg(ex_dst_reg), .ex_payload(ex_payload)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Monitor: consumes a uop whenever execute accepts it outside flush/reset.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
    end else if (ex_valid && ex_ready) begin
      exp_t got, want;
      got = {ex_src1_val, ex_src2_val, ex_dst_reg, ex_payload};
      total++;
      n_out++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got %h want none", got);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL sb_uop: got %h want %h", got, want);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_wb(input int p, input logic [5:0] idx, input logic [31:0] v);
    wb_valid[p]              = 1'b1;
    wb_dst_index[p*PW +: PW] = idx;
    wb_dst_val[p*32 +: 32]   = v;
  endtask

  task automatic drive(input logic [5:0] s1, input logic [5:0] s2, input logic u1,
                       input logic u2, input logic [5:0] d, input logic [47:0] pl);
    is_src1_reg = s1; is_src2_reg = s2; is_src1_used = u1; is_src2_used = u2;
    is_dst_reg = d; is_payload = pl;
  endtask

  task automatic issue(input logic [5:0] s1, input logic [5:0] s2, input logic u1,
                       input logic u2, input logic [5:0] d, input logic [47:0] pl,
                       input logic [31:0] e1, input logic [31:0] e2);
    int w;
    w = 0;
    drive(s1, s2, u1, u2, d, pl);
    is_valid = 1'b1;
    while (!is_ready && w < 50) begin
      tick();
      w++;
    end
    if (!is_ready) begin
      chk("issue_timeout", 64'd0, 64'd1);
    end else begin
      sb.push_back({e1, e2, d, pl});
    end
    tick();
    is_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 50) begin
      tick();
      w++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int n0;
    logic seen;
    for (int i = 0; i < 64; i++) prf[i] = 32'h1000 + i;
    prf[5] = 32'h11; prf[9] = 32'h22; prf[12] = 32'h99; prf[3] = 32'hFF; prf[7] = 32'h0;
    rst = 1'b1; flush = 1'b0; is_valid = 1'b0; ex_ready = 1'b1;
    wb_valid = '0; wb_dst_index = '0; wb_dst_val = '0;
    drive(6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 48'd0);
    tick(); tick();
    rst = 1'b0;
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_is_ready", 64'(is_ready), 64'd1);
    chk("rst_ex_vals", {ex_src1_val, ex_src2_val}, 64'd0);
    chk("rst_ex_dst_pl", {ex_dst_reg, ex_payload}, 64'd0);
    chk("rst_prf_regs", {prf_src1_reg, prf_src2_reg}, 64'd0);

    // Straight-line with latency check
    issue(6'd5, 6'd9, 1'b1, 1'b1, 6'd3, 48'hA1, 32'h11, 32'h22);
    chk("lat_n1_ex_valid", 64'(ex_valid), 64'd0);
    chk("lat_n1_prf_addr", {prf_src1_reg, prf_src2_reg}, {52'd0, 6'd5, 6'd9});
    tick();
    chk("lat_n2_ex_valid", 64'(ex_valid), 64'd1);
    drain();

    // Back-to-back stream of 10
    n0 = n_out;
    for (int k = 0; k < 10; k++)
      issue(6'(20 + k), 6'(40 + k), 1'b1, 1'b1, 6'(k), 48'hB000 + 48'(k),
            32'h1000 + 32'(20 + k), 32'h1000 + 32'(40 + k));
    drain();
    chk("stream_count", 64'(n_out - n0), 64'd10);

    // Same-cycle bypass, priority, preg 0
    issue(6'd7, 6'd8, 1'b1, 1'b1, 6'd4, 48'hC1, 32'hABCD, 32'h1008);
    set_wb(3, 6'd7, 32'hABCD); tick(); wb_valid = '0;
    issue(6'd7, 6'd8, 1'b1, 1'b1, 6'd4, 48'hC2, 32'h1234, 32'h1008);
    set_wb(3, 6'd7, 32'hABCD); set_wb(6, 6'd7, 32'h1234); tick(); wb_valid = '0;
    issue(6'd0, 6'd7, 1'b1, 1'b1, 6'd4, 48'hC3, 32'hCAFE, 32'hF00D);
    set_wb(7, 6'd0, 32'hCAFE); set_wb(2, 6'd7, 32'hBEEF); set_wb(5, 6'd7, 32'hF00D);
    tick(); wb_valid = '0;
    drain();

    // Unused source ignores PRF and bypass
    issue(6'd3, 6'd9, 1'b0, 1'b1, 6'd2, 48'hD1, 32'h0, 32'h22);
    set_wb(1, 6'd3, 32'h77); tick(); wb_valid = '0;
    drain();

    // Backpressure with snoop in B
    ex_ready = 1'b0;
    n0 = n_out;
    issue(6'd5, 6'd12, 1'b1, 1'b1, 6'd1, 48'hE1, 32'h11, 32'h55);
    issue(6'd5, 6'd9, 1'b1, 1'b1, 6'd2, 48'hE2, 32'h11, 32'h22);
    chk("bp_full_is_ready", 64'(is_ready), 64'd0);
    chk("bp_b_prf_val", 64'(ex_src2_val), 64'h99);
    tick();
    set_wb(0, 6'd12, 32'h55); tick(); wb_valid = '0;
    chk("bp_snoop_val", 64'(ex_src2_val), 64'h55);
    chk("bp_still_valid", 64'(ex_valid), 64'd1);
    tick();
    ex_ready = 1'b1;
    drain();
    chk("bp_count", 64'(n_out - n0), 64'd2);

    // Flush with both slots full and an issue in the flush cycle
    ex_ready = 1'b0;
    issue(6'd5, 6'd9, 1'b1, 1'b1, 6'd5, 48'hF1, 32'h11, 32'h22);
    issue(6'd5, 6'd9, 1'b1, 1'b1, 6'd6, 48'hF2, 32'h11, 32'h22);
    chk("fl_full_ex_valid", 64'(ex_valid), 64'd1);
    flush = 1'b1; is_valid = 1'b1; drive(6'd5, 6'd9, 1'b1, 1'b1, 6'd7, 48'hF3);
    tick();
    flush = 1'b0; is_valid = 1'b0;
    chk("fl_ex_valid", 64'(ex_valid), 64'd0);
    chk("fl_is_ready", 64'(is_ready), 64'd1);
    ex_ready = 1'b1;
    issue(6'd20, 6'd21, 1'b1, 1'b1, 6'd8, 48'hF4, 32'h1014, 32'h1015);
    chk("fl_post_n1", 64'(ex_valid), 64'd0);
    tick();
    chk("fl_post_n2", 64'(ex_valid), 64'd1);
    drain();

    // Flush while empty drops the uop offered in that cycle
    flush = 1'b1; is_valid = 1'b1; drive(6'd5, 6'd9, 1'b1, 1'b1, 6'd9, 48'hF5);
    chk("fl_empty_is_ready", 64'(is_ready), 64'd1);
    tick();
    flush = 1'b0; is_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      seen = seen | ex_valid;
      tick();
    end
    chk("fl_drop_no_valid", 64'(seen), 64'd0);

    // Reset mid-stall
    ex_ready = 1'b0;
    issue(6'd5, 6'd9, 1'b1, 1'b1, 6'd10, 48'h111, 32'h11, 32'h22);
    issue(6'd5, 6'd9, 1'b1, 1'b1, 6'd11, 48'h112, 32'h11, 32'h22);
    tick();
    rst = 1'b1;
    tick();
    chk("rs_ex_valid", 64'(ex_valid), 64'd0);
    chk("rs_ex_vals", {ex_src1_val, ex_src2_val}, 64'd0);
    chk("rs_ex_pl", 64'(ex_payload), 64'd0);
    chk("rs_prf_regs", {prf_src1_reg, prf_src2_reg}, 64'd0);
    rst = 1'b0; ex_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      seen = seen | ex_valid;
      tick();
    end
    chk("rs_no_valid", 64'(seen), 64'd0);
    n0 = n_out;
    for (int k = 0; k < 3; k++)
      issue(6'(30 + k), 6'(50 + k), 1'b1, 1'b1, 6'(k), 48'h2000 + 48'(k),
            32'h1000 + 32'(30 + k), 32'h1000 + 32'(50 + k));
    drain();
    chk("rs_resume_count", 64'(n_out - n0), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
